free_list_ctrl: RTL

// - Rename-stage controller for the map table: owns the physical-register free list (circular FIFO).
// - Allocates a new dest PR per dispatch and drives the map table SET-dest port.
// - Recycles old PRs at retire; rolls back speculative allocation on mispredict and drives map table restore.
// - Sits between dispatch/ROB and map_table; one dispatch and one retire per cycle.

---
 rtl/free_list_if.sv | 36 +++
 rtl/free_list_ctrl.sv | 100 ++++++++++
 2 files changed

// File: rtl/free_list_if.sv
// Rename-stage bus between dispatch/ROB/map table and the free list controller.
// master: dispatch/ROB side (drives requests); slave: free_list_ctrl.
interface free_list_if #(
  parameter int PHYS_REGS = 64,
  parameter int ARCH_REGS = 32
);
  localparam int PR_W = $clog2(PHYS_REGS);
  localparam int AR_W = $clog2(ARCH_REGS);

  logic            dispatch_valid;
  logic [AR_W-1:0] dispatch_dest;
  logic            dispatch_ready;
  logic            set_dest_enable;
  logic [PR_W-1:0] new_dest_pr_idx;
  logic            retire_valid;
  logic            retire_has_dest;
  logic [PR_W-1:0] retire_old_pr;
  logic            mispredict;
  logic            restore_enable;
  logic [PR_W:0]   free_count;
  logic            overflow_err;

  modport master (
    output dispatch_valid, dispatch_dest, retire_valid, retire_has_dest,
           retire_old_pr, mispredict,
    input  dispatch_ready, set_dest_enable, new_dest_pr_idx, restore_enable,
           free_count, overflow_err
  );

  modport slave (
    input  dispatch_valid, dispatch_dest, retire_valid, retire_has_dest,
           retire_old_pr, mispredict,
    output dispatch_ready, set_dest_enable, new_dest_pr_idx, restore_enable,
           free_count, overflow_err
  );
endinterface

// File: rtl/free_list_ctrl.sv
// Physical-register free list for the rename stage (circular FIFO).
// Allocates a PR per dispatch, recycles superseded PRs at retire and rolls the
// speculative head back to the retire head on mispredict.
// Optional feature macro: FL_BYPASS_EN -- a PR freed by retire while the list is
// empty is handed straight to a same-cycle dispatch instead of being queued.
module free_list_ctrl #(
  parameter int PHYS_REGS = 64,
  parameter int ARCH_REGS = 32
) (
  input logic        clk,
  input logic        reset_n,
  free_list_if.slave fl
);
  localparam int PR_W = $clog2(PHYS_REGS);
  localparam int AR_W = $clog2(ARCH_REGS);
  localparam logic [PR_W:0] FULL_CNT = (PR_W+1)'(PHYS_REGS - 1);
  localparam logic [PR_W:0] PTR_ONE  = (PR_W+1)'(1);

  typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_t;

  state_t          state;
  logic [PR_W-1:0] list_mem [PHYS_REGS];
  logic [PR_W:0]   spec_head;
  logic [PR_W:0]   ret_head;
  logic [PR_W:0]   tail;
  logic            overflow_q;

  logic [PR_W:0]   count;
  logic [PR_W:0]   ret_head_nxt;
  logic            empty;
  logic            full;
  logic            run_ok;
  logic            need_dest;
  logic            ret_pop;
  logic            push_req;
  logic            push_drop;
  logic            push_do;
  logic            alloc;
  logic            bypass;

  // Occupancy, allocation and recycle decisions for this cycle
  always_comb begin
    count        = tail - spec_head;
    empty        = (count == '0);
    full         = (count == FULL_CNT);
    run_ok       = reset_n && (state == RUN) && !fl.mispredict && fl.dispatch_valid;
    need_dest    = (fl.dispatch_dest != AR_W'(0));
    ret_pop      = fl.retire_valid && fl.retire_has_dest;
    push_req     = ret_pop && (fl.retire_old_pr != '0);
    bypass       = 1'b0;
`ifdef FL_BYPASS_EN
    bypass       = run_ok && need_dest && empty && push_req;
`endif
    alloc        = run_ok && need_dest && !empty;
    // A push into a full list only fits if an allocation frees a slot this cycle
    push_drop    = push_req && !bypass && full && !alloc;
    push_do      = push_req && !bypass && !push_drop;
    ret_head_nxt = ret_head + (ret_pop ? PTR_ONE : '0);
  end

  // Map-table / dispatch facing outputs; handshakes held low while in reset
  always_comb begin
    fl.dispatch_ready  = run_ok && (!need_dest || !empty || bypass);
    fl.set_dest_enable = alloc || bypass;
    fl.new_dest_pr_idx = reset_n ? list_mem[spec_head[PR_W-1:0]] : '0;
    if (bypass) fl.new_dest_pr_idx = fl.retire_old_pr;
    fl.restore_enable  = reset_n && fl.mispredict;
    fl.free_count      = count;
    fl.overflow_err    = overflow_q;
  end

  // Free-list storage, pointers, sticky overflow and RUN/RECOVER state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < PHYS_REGS; i++) begin
        list_mem[i] <= (i < PHYS_REGS - 1) ? PR_W'(i + 1) : '0;
      end
      spec_head  <= '0;
      ret_head   <= '0;
      tail       <= FULL_CNT;
      overflow_q <= 1'b0;
      state      <= RUN;
    end else begin
      if (push_do) begin
        list_mem[tail[PR_W-1:0]] <= fl.retire_old_pr;
        tail                     <= tail + PTR_ONE;
      end
      if (push_drop) overflow_q <= 1'b1;
      ret_head <= ret_head_nxt;
      // Rollback uses the retire head including this cycle's retirement
      if (fl.mispredict)  spec_head <= ret_head_nxt;
      else if (alloc)     spec_head <= spec_head + PTR_ONE;
      case (state)
        RUN:     state <= fl.mispredict ? RECOVER : RUN;
        RECOVER: state <= fl.mispredict ? RECOVER : RUN;
        default: state <= RUN;
      endcase
    end
  end
endmodule
